// File: rtl/q_mul_chan_sched_if.sv
// q_mul_chan_sched_if: sample, config, multiplier and output signals of the channel scheduler
interface q_mul_chan_sched_if #(
   parameter int N_CH       = 4,
   parameter int CH_BITS    = 2,
   parameter int DATA_WIDTH = 32,
   parameter int GAIN_WIDTH = 18
);
   logic [N_CH-1:0]            s_tvalid;
   logic [N_CH-1:0]            s_tready;
   logic [N_CH*DATA_WIDTH-1:0] s_tdata;
   logic                       cfg_we;
   logic [CH_BITS-1:0]         cfg_ch;
   logic [GAIN_WIDTH-1:0]      cfg_gain;
   logic                       mul_tvalid;
   logic                       mul_tready;
   logic [DATA_WIDTH-1:0]      mul_x;
   logic [GAIN_WIDTH-1:0]      mul_gain;
   logic                       res_tvalid;
   logic                       res_tready;
   logic [DATA_WIDTH-1:0]      res_y;
   logic                       m_tvalid;
   logic                       m_tready;
   logic [DATA_WIDTH-1:0]      m_tdata;
   logic [CH_BITS-1:0]         m_tdest;
   logic                       err_tag;
   modport master (
      input  s_tvalid, s_tdata, cfg_we, cfg_ch, cfg_gain, mul_tready, res_tvalid, res_y, m_tready,
      output s_tready, mul_tvalid, mul_x, mul_gain, res_tready, m_tvalid, m_tdata, m_tdest, err_tag
   );
   modport slave (
      output s_tvalid, s_tdata, cfg_we, cfg_ch, cfg_gain, mul_tready, res_tvalid, res_y, m_tready,
      input  s_tready, mul_tvalid, mul_x, mul_gain, res_tready, m_tvalid, m_tdata, m_tdest, err_tag
   );
endinterface

// File: rtl/q_mul_chan_sched.sv
// q_mul_chan_sched: round-robin sharing of one gain multiplier across channels, with result tagging
module q_mul_chan_sched #(
   parameter int                    N_CH       = 4,
   parameter int                    CH_BITS    = 2,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    GAIN_WIDTH = 18,
   parameter logic [GAIN_WIDTH-1:0] GAIN_RESET = 18'h1FFFF,
   parameter int                    TAG_DEPTH  = 2
) (
   input logic                clk,
   input logic                rst,
   q_mul_chan_sched_if.master bus
);
   localparam int PB = $clog2(TAG_DEPTH);
   logic [CH_BITS-1:0]    r_rr;
   logic [GAIN_WIDTH-1:0] r_gain [N_CH];
   logic [CH_BITS-1:0]    r_tag [TAG_DEPTH];
   logic [PB-1:0]         r_wp;
   logic [PB-1:0]         r_rp;
   logic [PB:0]           r_cnt;
   logic                  r_err;
   logic [CH_BITS-1:0]    w_grant;
   logic                  w_any;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_fire;
   logic                  w_pop;
   // first requesting channel at or after the round-robin pointer; descending scan so the nearest wins
   always_comb begin
      w_grant = '0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (bus.s_tvalid[(int'(r_rr) + i) % N_CH]) w_grant = CH_BITS'((int'(r_rr) + i) % N_CH);
   end
   assign w_any          = |bus.s_tvalid;
   assign w_full         = r_cnt == (PB+1)'(TAG_DEPTH);
   assign w_empty        = r_cnt == '0;
   assign bus.mul_tvalid = !rst & w_any & !w_full;
   assign bus.s_tready   = (rst | !w_any) ? '0 : N_CH'(bus.mul_tready & !w_full) << w_grant;
   assign bus.mul_x      = bus.s_tdata[w_grant*DATA_WIDTH +: DATA_WIDTH];
   assign bus.mul_gain   = r_gain[w_grant];
   assign w_fire         = bus.mul_tvalid & bus.mul_tready;
   assign bus.res_tready = !rst & bus.m_tready;
   assign bus.m_tvalid   = bus.res_tvalid;
   assign bus.m_tdata    = bus.res_y;
   assign bus.m_tdest    = w_empty ? '0 : r_tag[r_rp];
   assign w_pop          = bus.res_tvalid & bus.m_tready & !w_empty;
   assign bus.err_tag    = r_err;
   // pointer advance, tag FIFO bookkeeping and sticky orphan-result flag
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_rr  <= '0;
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_fire) begin
            r_rr <= (w_grant == CH_BITS'(N_CH - 1)) ? '0 : w_grant + 1'b1;
            r_wp <= r_wp + 1'b1;
         end
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + {{PB{1'b0}}, w_fire} - {{PB{1'b0}}, w_pop};
         if (bus.res_tvalid & w_empty) r_err <= 1'b1;
      end
   // tag storage needs no reset; entries are only read while the count says they are live
   always_ff @(posedge clk)
      if (w_fire) r_tag[r_wp] <= w_grant;
   // gain table, written after the read so a same-cycle issue sees the old gain
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < N_CH; i++) r_gain[i] <= GAIN_RESET;
      else if (bus.cfg_we && {1'b0, bus.cfg_ch} < (CH_BITS+1)'(N_CH)) r_gain[bus.cfg_ch] <= bus.cfg_gain;
endmodule

// File: tb/tb_q_mul_chan_sched.sv
// tb_q_mul_chan_sched: scoreboard bench with a behavioural multiplier and arbitration model
module tb_q_mul_chan_sched;
   localparam int N = 4, CB = 2, DW = 32, GW = 18, TD = 2;
   localparam logic [GW-1:0] GR = 18'h1FFFF;
   typedef struct { logic [CB-1:0] ch; logic [DW-1:0] y; } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   q_mul_chan_sched_if #(.N_CH(N), .CH_BITS(CB), .DATA_WIDTH(DW), .GAIN_WIDTH(GW)) bus();
   q_mul_chan_sched #(.N_CH(N), .CH_BITS(CB), .DATA_WIDTH(DW), .GAIN_WIDTH(GW), .GAIN_RESET(GR), .TAG_DEPTH(TD))
      dut (.clk(clk), .rst(rst), .bus(bus));
   int errors = 0, checks = 0, fires = 0, f0;
   int rr_m = 0, mcap = 1;
   logic [GW-1:0] gain_m [N];
   logic exp_err = 1'b0;
   logic force_res = 1'b0;
   exp_t sq [$];
   logic mv0 = 1'b0, mv1 = 1'b0;
   logic [DW-1:0] my0 = '0, my1 = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   // Q1.31 sample times Q1.17 gain, rescaled back to Q1.31
   function automatic logic [DW-1:0] prod(input logic [DW-1:0] x, input logic [GW-1:0] g);
      longint p;
      p = longint'($signed(x)) * longint'($signed(g));
      return DW'(p >>> (GW - 1));
   endfunction

   // multiplier stand-in: 1-cycle latency, holds its result under backpressure, mcap results buffered
   assign bus.res_tvalid = mv0 | force_res;
   assign bus.res_y      = my0;
   assign bus.mul_tready = (int'(mv0) + int'(mv1) < mcap) || (bus.res_tready && mv0);
   always @(posedge clk or posedge rst)
      if (rst) begin
         mv0 <= 1'b0;
         mv1 <= 1'b0;
      end else begin
         logic v0, v1;
         logic [DW-1:0] y0, y1;
         v0 = mv0; v1 = mv1; y0 = my0; y1 = my1;
         if (mv0 && bus.res_tready) begin v0 = v1; y0 = y1; v1 = 1'b0; end
         if (bus.mul_tvalid && bus.mul_tready) begin
            if (!v0) begin v0 = 1'b1; y0 = prod(bus.mul_x, bus.mul_gain); end
            else begin v1 = 1'b1; y1 = prod(bus.mul_x, bus.mul_gain); end
         end
         mv0 <= v0; mv1 <= v1; my0 <= y0; my1 <= y1;
      end

   // issue side: reference arbitration and gain model, pushes expected results
   always @(negedge clk) begin
      #1;
      if (rst) begin
         chk("rst_s_tready", bus.s_tready, 0);
         chk("rst_mul_tvalid", bus.mul_tvalid, 0);
         chk("rst_res_tready", bus.res_tready, 0);
         sq.delete();
         rr_m = 0;
         for (int i = 0; i < N; i++) gain_m[i] = GR;
      end else begin
         int g;
         bit any, full, fire;
         logic [N-1:0] er;
         g = -1;
         for (int i = 0; i < N; i++) if (g < 0 && bus.s_tvalid[(rr_m + i) % N]) g = (rr_m + i) % N;
         any = g >= 0;
         full = sq.size() == TD;
         fire = any && !full && bus.mul_tready;
         er = '0;
         if (fire) er[g] = 1'b1;
         chk("mul_tvalid", bus.mul_tvalid, any && !full);
         chk("s_tready", bus.s_tready, er);
         if (any && !full) begin
            chk("mul_x", bus.mul_x, bus.s_tdata[g*DW +: DW]);
            chk("mul_gain", bus.mul_gain, gain_m[g]);
         end
         if (fire) begin
            sq.push_back('{ch: CB'(g), y: prod(bus.s_tdata[g*DW +: DW], gain_m[g])});
            rr_m = (g + 1) % N;
            fires++;
         end
         if (bus.cfg_we && int'(bus.cfg_ch) < N) gain_m[bus.cfg_ch] = bus.cfg_gain;
      end
   end

   // output side: pops the scoreboard on each result handshake
   always @(negedge clk) begin
      #2;
      if (rst) exp_err = 1'b0;
      else begin
         chk("err_tag", bus.err_tag, exp_err);
         if (bus.m_tvalid && sq.size() == 0) begin
            exp_err = 1'b1;
            if (bus.m_tready) chk("m_tdest_empty", bus.m_tdest, 0);
         end else if (bus.m_tvalid && bus.m_tready) begin
            exp_t e;
            e = sq.pop_front();
            chk("m_tdata", bus.m_tdata, e.y);
            chk("m_tdest", bus.m_tdest, e.ch);
         end
      end
   end

   task automatic drive(input logic [N-1:0] v, input logic mt);
      @(negedge clk);
      bus.s_tvalid = v;
      bus.m_tready = mt;
      bus.s_tdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.cfg_we   = 1'b0;
   endtask

   initial begin
      bus.s_tvalid = '0; bus.s_tdata = '0; bus.m_tready = 1'b1;
      bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_gain = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      drive(4'b0100, 1);
      bus.s_tdata[2*DW +: DW] = 32'h40000000;
      drive(4'b0000, 1);
      #3;
      chk("dflt_valid", bus.m_tvalid, 1);
      chk("dflt_data", bus.m_tdata, 32'h3FFFE000);
      chk("dflt_dest", bus.m_tdest, 2);
      f0 = fires;
      repeat (12) drive(4'hF, 1);
      #2;
      chk("full_load_fires", fires - f0, 12);
      drive(4'b0010, 1);
      bus.s_tdata[DW +: DW] = 32'h40000000;
      bus.cfg_we = 1'b1; bus.cfg_ch = 2'd1; bus.cfg_gain = 18'h10000;
      drive(4'b0010, 1);
      bus.s_tdata[DW +: DW] = 32'h40000000;
      #3;
      chk("gw_old_data", bus.m_tdata, 32'h3FFFE000);
      chk("gw_old_dest", bus.m_tdest, 1);
      drive(4'b0000, 1);
      #3;
      chk("gw_new_data", bus.m_tdata, 32'h20000000);
      repeat (3) drive(4'hF, 1);
      repeat (3) drive(4'hF, 0);
      #3;
      chk("bp_s_tready", bus.s_tready, 0);
      repeat (7) drive(4'hF, 0);
      repeat (10) drive(4'hF, 1);
      drive(4'b0010, 1);
      drive(4'b1010, 1);
      #3;
      chk("sparse_0", bus.s_tready, 4'b1000);
      drive(4'b1010, 1);
      #3;
      chk("sparse_1", bus.s_tready, 4'b0010);
      drive(4'b1010, 1);
      #3;
      chk("sparse_2", bus.s_tready, 4'b1000);
      for (int k = 0; k < 300; k++) begin
         drive(N'($urandom()), $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) begin
            bus.cfg_we = 1'b1;
            bus.cfg_ch = CB'($urandom());
            bus.cfg_gain = GW'($urandom());
         end
      end
      repeat (4) drive(4'h0, 1);
      mcap = 2;
      repeat (4) drive(4'hF, 0);
      #3;
      chk("tags_full_stall", bus.mul_tvalid, 0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) drive(4'hF, 0);
      drive(4'hF, 0);
      rst = 1'b0;
      mcap = 1;
      #3;
      chk("post_rst_m_tvalid", bus.m_tvalid, 0);
      chk("post_rst_mul_tvalid", bus.mul_tvalid, 1);
      repeat (4) drive(4'h0, 1);
      drive(4'h0, 1);
      force_res = 1'b1;
      drive(4'h0, 1);
      force_res = 1'b0;
      repeat (4) drive(4'h0, 1);
      #3;
      chk("err_sticky", bus.err_tag, 1);
      @(negedge clk);
      rst = 1'b1;
      drive(4'h0, 1);
      rst = 1'b0;
      #3;
      chk("err_cleared", bus.err_tag, 0);
      repeat (20) drive(4'hF, 1);
      repeat (5) drive(4'h0, 1);
      #3;
      chk("drain", sq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
